// File: rtl/im_loader.sv
// im_loader: writer side of the instruction memory.
// Takes a big-endian byte stream (16-bit word count, then 4-byte words, MSB
// first) from the UART receiver and writes the words into the instruction
// memory write port. The CPU is held in hold while a load runs.
module im_loader #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    // Counter wide enough to hold TIMEOUT; TIMEOUT of 0 or 1 still needs one bit.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        DONE,
        ERR
    } state_t;

    state_t            state_reg;
    logic [15:0]       len_reg;
    logic [1:0]        byte_idx_reg;
    logic [ADDR_W-1:0] word_idx_reg;
    logic [31:0]       asm_reg;
    logic              pend_reg;
    logic [TW-1:0]     tmo_reg;

    logic              im_we_reg;
    logic [ADDR_W-1:0] im_addr_reg;
    logic [31:0]       im_wdata_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic              cpu_hold_reg;

    logic              tmo_hit;
    logic              last_word;
    logic [15:0]       len_full;
    logic              len_too_big;

    // Idle-cycle limit reached on this edge (disabled when TIMEOUT is 0).
    assign tmo_hit     = (TIMEOUT != 0) && ((32'(tmo_reg) + 32'd1) == 32'(TIMEOUT));
    // The pending word is the final one of the stream.
    assign last_word   = (32'(word_idx_reg) == (32'(len_reg) - 32'd1));
    // Complete word count as seen when the low length byte arrives.
    assign len_full    = {len_reg[15:8], byte_data};
    assign len_too_big = (32'(len_full) > (32'd1 << ADDR_W));

    // Loader state machine; every output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            byte_idx_reg <= '0;
            word_idx_reg <= '0;
            asm_reg      <= '0;
            pend_reg     <= 1'b0;
            tmo_reg      <= '0;
            im_we_reg    <= 1'b0;
            im_addr_reg  <= '0;
            im_wdata_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            cpu_hold_reg <= 1'b0;
        end else begin
            im_we_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE, ERR: begin
                    // Bytes arriving here (including alongside start) are dropped.
                    if (start) begin
                        state_reg    <= LEN_HI;
                        busy_reg     <= 1'b1;
                        cpu_hold_reg <= 1'b1;
                        done_reg     <= 1'b0;
                        err_reg      <= 1'b0;
                        im_addr_reg  <= '0;
                        len_reg      <= '0;
                        byte_idx_reg <= '0;
                        word_idx_reg <= '0;
                        pend_reg     <= 1'b0;
                        tmo_reg      <= '0;
                    end
                end

                LEN_HI: begin
                    if (byte_valid) begin
                        len_reg[15:8] <= byte_data;
                        tmo_reg       <= '0;
                        state_reg     <= LEN_LO;
                    end else if (tmo_hit) begin
                        state_reg    <= ERR;
                        err_reg      <= 1'b1;
                        busy_reg     <= 1'b0;
                        cpu_hold_reg <= 1'b0;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end

                LEN_LO: begin
                    if (byte_valid) begin
                        len_reg <= len_full;
                        tmo_reg <= '0;
                        if (len_full == 16'd0) begin
                            state_reg    <= DONE;
                            done_reg     <= 1'b1;
                            busy_reg     <= 1'b0;
                            cpu_hold_reg <= 1'b0;
                        end else if (len_too_big) begin
                            state_reg    <= ERR;
                            err_reg      <= 1'b1;
                            busy_reg     <= 1'b0;
                            cpu_hold_reg <= 1'b0;
                        end else begin
                            state_reg <= DATA;
                        end
                    end else if (tmo_hit) begin
                        state_reg    <= ERR;
                        err_reg      <= 1'b1;
                        busy_reg     <= 1'b0;
                        cpu_hold_reg <= 1'b0;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end

                DATA: begin
                    // A word assembled on the previous edge is written now.
                    if (pend_reg) begin
                        im_we_reg    <= 1'b1;
                        im_wdata_reg <= asm_reg;
                        im_addr_reg  <= word_idx_reg;
                        word_idx_reg <= word_idx_reg + 1'b1;
                        pend_reg     <= 1'b0;
                        if (last_word) begin
                            state_reg    <= DONE;
                            done_reg     <= 1'b1;
                            busy_reg     <= 1'b0;
                            cpu_hold_reg <= 1'b0;
                        end
                    end
                    // Byte intake continues alongside a write, except after the last one.
                    if (!(pend_reg && last_word)) begin
                        if (byte_valid) begin
                            asm_reg      <= {asm_reg[23:0], byte_data};
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                            tmo_reg      <= '0;
                            if (byte_idx_reg == 2'd3) begin
                                pend_reg <= 1'b1;
                            end
                        end else if (tmo_hit) begin
                            state_reg    <= ERR;
                            err_reg      <= 1'b1;
                            busy_reg     <= 1'b0;
                            cpu_hold_reg <= 1'b0;
                            pend_reg     <= 1'b0;
                        end else begin
                            tmo_reg <= tmo_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign im_we    = im_we_reg;
    assign im_addr  = im_addr_reg;
    assign im_wdata = im_wdata_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign cpu_hold = cpu_hold_reg;

endmodule

// File: tb/tb_im_loader.sv
// Directed testbench for im_loader (ADDR_W=10, TIMEOUT=16).
module tb_im_loader;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;

    int compared   = 0;
    int mismatched = 0;

    // Write monitor state
    int                we_cnt   = 0;
    int                long_cnt = 0;
    logic              we_prev  = 1'b0;
    bit                quiet    = 1'b0;
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];

    im_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_hold  (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write pulse on the falling edge; flag pulses longer than one cycle.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            we_cnt++;
            wa_q.push_back(im_addr);
            wd_q.push_back(im_wdata);
            if (we_prev === 1'b1) long_cnt++;
            if (!quiet) $display("write: addr=%0h data=%08h", im_addr, im_wdata);
        end
        we_prev = im_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input int i);
        logic [15:0] v;
        v = 16'(i);
        return {v ^ 16'hA5C3, ~v};
    endfunction

    int base;
    int bad;
    logic [31:0] w;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #23;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_outs", {25'd0, im_we, done, err, cpu_hold, 3'd0}, 32'd0);
        chk("reset_addr_data", 32'(im_addr) | im_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reset mid-load: length 1, two data bytes, then async reset.
        do_start();
        chk("start_busy", {30'd0, busy, cpu_hold}, 32'd3);
        send(8'h00); send(8'h01); send(8'h11); send(8'h22);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_outs", {25'd0, im_we, busy, done, err, cpu_hold, 2'd0}, 32'd0);
        chk("midrst_addr_data", 32'(im_addr) | im_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(8'h33); send(8'h44); tick(); tick();
        chk("midrst_no_we", 32'(we_cnt), 32'd0);
        chk("midrst_idle", {29'd0, busy, done, err}, 32'd0);

        // Basic load: two words.
        base = we_cnt;
        do_start();
        send(8'h00); send(8'h02);
        send(8'h20); send(8'h08); send(8'h00); send(8'h05);
        chk("basic_latency", 32'(im_we), 32'd0);
        tick();
        chk("basic_w0_we", 32'(im_we), 32'd1);
        chk("basic_w0_addr", 32'(im_addr), 32'd0);
        chk("basic_w0_data", im_wdata, 32'h20080005);
        tick();
        send(8'h8C); send(8'h09); send(8'h00); send(8'h04);
        chk("basic_busy_before_last", {30'd0, busy, done}, 32'd2);
        tick();
        chk("basic_w1_we", 32'(im_we), 32'd1);
        chk("basic_w1_addr", 32'(im_addr), 32'd1);
        chk("basic_w1_data", im_wdata, 32'h8C090004);
        chk("basic_done_with_last", {28'd0, busy, done, err, cpu_hold}, 32'h4);
        send(8'hFF);  // ignored: already DONE
        tick();
        chk("basic_hold_addr", 32'(im_addr), 32'd1);
        chk("basic_hold_data", im_wdata, 32'h8C090004);
        chk("basic_pulses", 32'(we_cnt - base), 32'd2);
        chk("basic_pulse_len", 32'(long_cnt), 32'd0);

        // Zero length.
        base = we_cnt;
        do_start();
        chk("zero_done_cleared", 32'(done), 32'd0);
        send(8'h00); send(8'h00);
        chk("zero_flags", {29'd0, busy, done, err}, 32'd2);
        tick(); tick();
        chk("zero_no_we", 32'(we_cnt - base), 32'd0);

        // Oversize: N=1025.
        base = we_cnt;
        do_start();
        send(8'h04); send(8'h01);
        chk("over_flags", {28'd0, busy, done, err, cpu_hold}, 32'd2);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78); tick();
        chk("over_no_we", 32'(we_cnt - base), 32'd0);

        // Timeout: length 1, two data bytes, then idle.
        base = we_cnt;
        do_start();
        chk("tmo_err_cleared", 32'(err), 32'd0);
        send(8'h00); send(8'h01); send(8'hAB); send(8'hCD);
        repeat (TIMEOUT - 1) tick();
        chk("tmo_not_yet", {30'd0, busy, err}, 32'd2);
        tick();
        chk("tmo_err", {28'd0, busy, done, err, cpu_hold}, 32'd2);
        chk("tmo_no_we", 32'(we_cnt - base), 32'd0);

        // Recovery load after timeout.
        base = we_cnt;
        do_start();
        send(8'h00); send(8'h01);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        tick();
        chk("rec_addr", 32'(im_addr), 32'd0);
        chk("rec_data", im_wdata, 32'hDEADBEEF);
        chk("rec_flags", {29'd0, busy, done, err}, 32'd2);
        tick();
        chk("rec_pulses", 32'(we_cnt - base), 32'd1);

        // Full memory: N=1024, back-to-back bytes.
        quiet = 1'b1;
        wa_q.delete();
        wd_q.delete();
        base = we_cnt;
        do_start();
        send(8'h04); send(8'h00);
        chk("full_accepted", {30'd0, busy, err}, 32'd2);
        for (int i = 0; i < 1024; i++) begin
            w = word_of(i);
            send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
        end
        tick();
        chk("full_done", {29'd0, busy, done, err}, 32'd2);
        chk("full_last_addr", 32'(im_addr), 32'h3FF);
        tick();
        chk("full_pulses", 32'(we_cnt - base), 32'd1024);
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++) begin
            if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== word_of(i)) bad++;
        end
        chk("full_contents_bad", 32'(bad), 32'd0);
        chk("full_pulse_len", 32'(long_cnt), 32'd0);
        $display("full load: %0d writes", we_cnt - base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer side of the instruction memory: receives a byte stream (from the board UART receiver) and writes 32-bit instruction words into the instruction memory's write port.
- Lets programs be loaded on the board without rebuilding the hex image.
- Holds the CPU in hold (`cpu_hold`) while a load is in progress.
- Sits between the UART RX block and the instruction memory write port.

Parameters:
- ADDR_W, 10, instruction memory word-address width (depth = 2^ADDR_W = 1024 words)
- TIMEOUT, 1000000, idle clock cycles allowed between bytes during a load before abort; 0 disables the timeout

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  load request, sampled each cycle
- byte_valid  input  1  single-cycle strobe: byte_data is valid this cycle
- byte_data  input  8  received byte
- im_we  output  1  instruction memory write enable, one-cycle pulse per word
- im_addr  output  ADDR_W  word address for the write
- im_wdata  output  32  word to write
- busy  output  1  high while a load is in progress
- done  output  1  high after a successful load, until the next start
- err  output  1  high after an aborted load, until the next start
- cpu_hold  output  1  equal to busy; CPU is frozen while high

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: im_we, im_addr, im_wdata, busy, done, err, cpu_hold.
  - Byte counter, word counter, length register and timeout counter cleared.
  - Reset asserted mid-load aborts immediately; no further writes are issued.
- Stream format (big-endian, MIPS order):
  - Bytes 0-1: 16-bit word count N, high byte first.
  - Then N words of 4 bytes each; the first byte of a word goes to bits [31:24].
- States: IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR.
  - IDLE/DONE/ERR: start=1 -> LEN_HI; clear done, err, im_addr, counters; busy=1 from the next cycle. byte_valid is ignored in these states.
  - LEN_HI: on byte_valid, latch N[15:8] -> LEN_LO.
  - LEN_LO: on byte_valid, latch N[7:0], then evaluate:
    - N=0 -> DONE, no writes.
    - N>2^ADDR_W -> ERR, no writes.
    - otherwise -> DATA.
  - DATA: each byte_valid shifts the byte into the 32-bit assembly register (shift left 8) and increments the byte index mod 4.
    - On the 4th byte: next cycle im_we=1 for exactly one cycle, with im_wdata = assembled word and im_addr = current word index.
    - The word index increments after the write.
    - When the write of word N-1 is issued -> DONE in the same cycle as that im_we pulse.
  - DONE: done=1, busy=0. ERR: err=1, busy=0.
- Write latency: im_we rises on the first rising edge after the edge that accepted the 4th byte. im_addr and im_wdata are stable while im_we=1 and hold their values afterwards.
- Timeout:
  - In LEN_HI, LEN_LO and DATA, a counter increments every cycle without byte_valid and clears on byte_valid or on state entry.
  - When the counter reaches TIMEOUT (TIMEOUT≠0) -> ERR.
  - Words already written remain in memory; the partial word is discarded.
- Simultaneous events:
  - start while busy is ignored.
  - byte_valid in the same cycle as start (from IDLE/DONE/ERR) is ignored; the length header begins with the next byte.
  - byte_valid in the cycle of the final im_we (state already DONE) is ignored.
- Back-to-back bytes (byte_valid every cycle) are supported with no stall; no backpressure exists.
- Address wrap cannot occur: N is bounded by 2^ADDR_W.
- cpu_hold = busy, registered; no glitches.

Test Plan:
- Reset mid-load: after 2 data bytes of a load, pull rst_n low asynchronously -> all outputs 0 immediately, state IDLE, no im_we afterwards.
- Basic load: start, then bytes 00 02 | 20 08 00 05 | 8C 09 00 04.
  - im_we pulse with addr 0, data 0x20080005; then addr 1, data 0x8C090004.
  - done=1, busy=0 after the second write.
  - Exactly 2 pulses, each 1 cycle long.
- Zero length: start, bytes 00 00 -> done=1, no im_we.
- Oversize: start, bytes 04 01 (N=1025) with ADDR_W=10 -> err=1, no im_we.
- Full memory: N=0x0400 followed by 4096 back-to-back bytes -> 1024 writes, last at addr 0x3FF; done=1.
- Timeout: TIMEOUT=16; send length 00 01 and 2 data bytes, then idle 16 cycles -> err=1, busy=0, no im_we. A subsequent start with a valid stream loads correctly and sets done (err cleared).
